// File: rtl/seq_mult16_if.sv
// Start/busy/result handshake between the multiplier tester and
// the iterative multiplier. The tester is master, the multiplier is slave.
interface seq_mult16_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               inject_error;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start,
    output a,
    output b,
    output inject_error,
    input  busy,
    input  done,
    input  result
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  inject_error,
    output busy,
    output done,
    output result
  );
endinterface

// File: rtl/seq_mult16.sv
// Iterative shift-add unsigned multiplier, WIDTH iterations per product.
// Optional fault inject flips result bit 0 of the captured operation.
module seq_mult16 #(
  parameter int WIDTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  seq_mult16_if.slave  m_if
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             inj_q, inj_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W2-1:0]    result_q, result_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      inj_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      inj_q    <= inj_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    inj_d    = inj_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (m_if.start) begin
          mcand_d  = W2'(m_if.a);
          mplier_d = m_if.b;
          acc_d    = '0;
          count_d  = '0;
          inj_d    = m_if.inject_error;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Fixed iteration count: no early exit on zero multiplier
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == LAST) state_d = DONE;
      end
      DONE: begin
        result_d = acc_q ^ W2'(inj_q);
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_if.busy   = busy_q;
  assign m_if.done   = done_q;
  assign m_if.result = result_q;
endmodule

// File: tb/tb_seq_mult16.sv
// Scoreboard bench for seq_mult16: driver pushes expected products,
// a monitor pops and compares on every done pulse.
module tb_seq_mult16;
  localparam int W  = 16;
  localparam int W2 = 2 * W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_mult16_if #(.WIDTH(W)) bus ();

  seq_mult16 #(.WIDTH(W)) dut (
    .clock (clk),
    .reset (rst),
    .m_if  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  logic [W2-1:0] last_res = '0;
  logic [W2-1:0] exp_q[$];

  function automatic logic [W2-1:0] model(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic inj
  );
    logic [W2-1:0] p;
    p = W2'(x) * W2'(y);
    p[0] = p[0] ^ inj;
    return p;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      busy_cnt = 0;
      last_res = '0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: result 0x%0h, nothing pending",
                   bus.result);
        end else begin
          chk("result", bus.result, exp_q.pop_front());
          chk("busy_cycles", busy_cnt, W + 1);
          chk("busy_low_at_done", bus.busy, 0);
        end
        busy_cnt = 0;
        last_res = bus.result;
      end else begin
        chk("result_hold", bus.result, last_res);
      end
    end
  end

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic inj);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%0b, required 0", bus.busy);
    end
    bus.a = x;
    bus.b = y;
    bus.inject_error = inj;
    bus.start = 1'b1;
    exp_q.push_back(model(x, y, inj));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.inject_error = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int acc_cyc[$];
    int k;
    int n;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.inject_error = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    @(negedge clk);
    rst = 1'b0;

    start_op(16'h0003, 16'h0005, 1'b0);
    drain();
    start_op(16'hFFFF, 16'hFFFF, 1'b0);
    start_op(16'h8000, 16'h0002, 1'b0);
    start_op(16'h0000, 16'h1234, 1'b0);
    start_op(16'h0002, 16'h0003, 1'b1);
    start_op(16'h0002, 16'h0003, 1'b0);
    drain();

    // Start request while busy must be ignored
    start_op(16'h0004, 16'h0004, 1'b0);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.a = 16'h00FF;
    bus.b = 16'h00FF;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (5) @(negedge clk);

    // Held-high start re-runs with one idle cycle between runs
    @(negedge clk);
    bus.a = 16'h0007;
    bus.b = 16'h0009;
    bus.inject_error = 1'b0;
    bus.start = 1'b1;
    k = 0;
    n = 0;
    while (k < 3 && n < 100) begin
      if (!bus.busy) begin
        exp_q.push_back(model(16'h0007, 16'h0009, 1'b0));
        acc_cyc.push_back(cyc);
        k++;
        if (k == 3) break;
      end
      @(negedge clk);
      n++;
    end
    chk("held_start_runs", k, 3);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (acc_cyc.size() == 3) begin
      chk("rerun_gap0", acc_cyc[1] - acc_cyc[0], W + 2);
      chk("rerun_gap1", acc_cyc[2] - acc_cyc[1], W + 2);
    end
    drain();

    // Asynchronous reset mid-run aborts the operation
    start_op(16'h1234, 16'h5678, 1'b0);
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_result", bus.result, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    start_op(16'h1234, 16'h5678, 1'b0);
    drain();

    for (int i = 0; i < 25; i++) begin
      start_op(W'($urandom), W'($urandom), $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
